// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// unit state enum and small op-classification helpers used by decode logic.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    logic v;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    logic v;
    case (op)
      OP_MULH, OP_DIV, OP_REM: v = 1'b1;
      default:                 v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/muldiv_seq_operand_prep.sv
// Operand conditioning: converts signed operands to magnitudes, derives the
// result-negate flags and flags the two divide cases that skip the iteration.
module md_operand_prep
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg_lo,
  output logic             o_neg_hi,
  output logic             o_div_zero,
  output logic             o_div_ovf
);

  logic w_a_neg;
  logic w_b_neg;

  // Magnitudes and sign bookkeeping; neg_lo covers product/quotient, neg_hi the remainder
  always_comb begin
    w_a_neg    = op_a_signed(i_op) & i_a[WIDTH-1];
    w_b_neg    = op_b_signed(i_op) & i_b[WIDTH-1];
    o_mag_a    = w_a_neg ? -i_a : i_a;
    o_mag_b    = w_b_neg ? -i_b : i_b;
    o_neg_lo   = w_a_neg ^ w_b_neg;
    o_neg_hi   = w_a_neg;
    o_div_zero = op_is_div(i_op) && (i_b == {WIDTH{1'b0}});
    o_div_ovf  = op_is_div(i_op) && !i_op[0]
                 && (i_a == {1'b1, {(WIDTH-1){1'b0}}})
                 && (i_b == {WIDTH{1'b1}});
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply / restoring divide unit, one bit per BUSY cycle,
// sharing one 2*WIDTH accumulator between both algorithms.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [WIDTH-1:0]   r_result;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg_lo;
  logic               w_neg_hi;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic               w_accept;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_res;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  md_operand_prep #(.WIDTH(WIDTH)) u_prep (
    .i_op       (in_op),
    .i_a        (in_a),
    .i_b        (in_b),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_neg_lo   (w_neg_lo),
    .o_neg_hi   (w_neg_hi),
    .o_div_zero (w_div_zero),
    .o_div_ovf  (w_div_ovf)
  );

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign out_result   = r_result;
  assign out_div_zero = r_div_zero;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_special = w_div_zero | w_div_ovf;

  // Immediate results for divide-by-zero and signed overflow
  always_comb begin
    w_special_res = {WIDTH{1'b0}};
    if (w_div_zero) begin
      if (op_is_rem(in_op)) begin
        w_special_res = in_a;
      end else begin
        w_special_res = {WIDTH{1'b1}};
      end
    end else if (w_div_ovf) begin
      if (op_is_rem(in_op)) begin
        w_special_res = {WIDTH{1'b0}};
      end else begin
        w_special_res = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else begin
      w_special_res = {WIDTH{1'b0}};
    end
  end

  // One iteration: multiply adds into the high half then shifts right;
  // divide shifts left and keeps the trial subtraction when it stays non-negative
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    if (op_is_div(r_op)) begin
      if (!w_div_diff[WIDTH]) begin
        w_acc_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Sign restoration and result selection from the last iteration's value
  always_comb begin
    w_prod = r_neg_lo ? -w_acc_step : w_acc_step;
    w_quot = r_neg_lo ? -w_acc_step[WIDTH-1:0] : w_acc_step[WIDTH-1:0];
    w_rem  = r_neg_hi ? -w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[2*WIDTH-1:WIDTH];
    case (r_op)
      OP_MUL:                         w_final = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   w_final = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:                w_final = w_quot;
      OP_REM, OP_REMU:                w_final = w_rem;
      default:                        w_final = {WIDTH{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state; flush outranks both accept and result handoff
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_state_next = w_special ? DONE : BUSY;
          end else begin
            w_state_next = IDLE;
          end
        end
        BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = DONE;
          end else begin
            w_state_next = BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = DONE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_op       <= 3'b000;
      r_acc      <= {(2*WIDTH){1'b0}};
      r_opnd     <= {WIDTH{1'b0}};
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_result   <= {WIDTH{1'b0}};
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_op     <= in_op;
      r_neg_lo <= w_neg_lo;
      r_neg_hi <= w_neg_hi;
      if (w_special) begin
        r_cnt      <= {CNT_W{1'b0}};
        r_result   <= w_special_res;
        r_div_zero <= w_div_zero;
      end else begin
        r_cnt  <= CNT_W'(WIDTH);
        r_acc  <= {{WIDTH{1'b0}}, (op_is_div(in_op) ? w_mag_a : w_mag_b)};
        r_opnd <= op_is_div(in_op) ? w_mag_b : w_mag_a;
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_result   <= w_final;
        r_div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed vector table,
// randomized ops against an arithmetic reference, and handshake corner cases.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_div_zero;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_div_zero (out_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the op definitions
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic dz, output int lat);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    int              ia;
    int              ib;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    res = 32'h0;
    dz  = 1'b0;
    lat = 33;
    case (op)
      OP_MUL:    begin p = ua * ub;           res = p[31:0];  end
      OP_MULH:   begin p = sa * sb;           res = p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); res = p[63:32]; end
      OP_MULHU:  begin p = ua * ub;           res = p[63:32]; end
      OP_DIV, OP_REM: begin
        if (b == 32'h0) begin
          lat = 1; dz = 1'b1;
          res = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          res = (op == OP_DIV) ? 32'h8000_0000 : 32'h0;
        end else begin
          res = (op == OP_DIV) ? 32'(ia / ib) : 32'(ia % ib);
        end
      end
      default: begin
        if (b == 32'h0) begin
          lat = 1; dz = 1'b1;
          res = (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        end else begin
          res = (op == OP_DIVU) ? (a / b) : (a % b);
        end
      end
    endcase
  endfunction

  // Issue one request, scramble inputs after accept, wait for and check the result
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dz, input int exp_lat,
                        input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (exp_lat > 0) chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/result"},   64'(out_result),   64'(exp_res));
    chk({tag, "/div_zero"}, 64'(out_div_zero), 64'(exp_dz));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        edz;
    int          elat;
    int          seen;
    logic [31:0] held;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 32'h0; in_b = 32'h0;
    flush = 1'b0; out_ready = 1'b0;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[6]  = '{OP_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0, 33};
    vecs[7]  = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[8]  = '{OP_REMU,   32'd5,          32'd0,         32'd5,         1'b1, 1};
    vecs[9]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    vecs[10] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    vecs[11] = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[12] = '{OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1, 1};
    vecs[13] = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33};

    repeat (3) @(posedge clk);
    #1;
    chk("reset/out_valid",  64'(out_valid),    64'd0);
    chk("reset/out_result", 64'(out_result),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset/in_ready",     64'(in_ready),     64'd1);
    chk("reset/out_div_zero", 64'(out_div_zero), 64'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_model(op, a, b, er, edz, elat);
      run_op(op, a, b, er, edz, elat, $sformatf("rnd%0d_op%0d", i, op));
    end

    // Result held in DONE while consumer stalls; competing request must not slip in
    @(negedge clk);
    in_op = OP_MUL; in_a = 32'd1234; in_b = 32'd5678; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    while (seen < 100 && !out_valid) begin
      @(negedge clk);
      seen++;
    end
    held = out_result;
    chk("hold/first_result", 64'(held), 64'd7006652);
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd99; in_b = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d/result", k),    64'(out_result), 64'd7006652);
      chk($sformatf("hold%0d/in_ready", k),  64'(in_ready),   64'd0);
      chk($sformatf("hold%0d/out_valid", k), 64'(out_valid),  64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("release/in_ready",  64'(in_ready),  64'd1);
    chk("release/out_valid", 64'(out_valid), 64'd0);

    // Reset pulse in the middle of an iteration
    run_op(OP_DIVU, 32'd99, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "pre_reset");
    @(negedge clk);
    in_op = OP_MULHU; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/out_valid",    64'(out_valid),    64'd0);
    chk("rst_mid/out_result",   64'(out_result),   64'd0);
    chk("rst_mid/out_div_zero", 64'(out_div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_model(OP_DIV, 32'hFFFF_FC18, 32'd7, er, edz, elat);
    run_op(OP_DIV, 32'hFFFF_FC18, 32'd7, er, edz, elat, "post_reset");

    // Flush during the fifth BUSY cycle
    @(negedge clk);
    in_op = OP_MUL; in_a = 32'd3; in_b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("flush/busy_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush/no_out_valid", 64'(seen), 64'd0);
    run_op(OP_REM, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, 1'b0, 33, "post_flush");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port in_op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port in_a  input  WIDTH  operand A (multiplicand/dividend).
REQ-008 SHALL have port in_b  input  WIDTH  operand B (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_result  output  WIDTH  result.
REQ-013 SHALL have port out_div_zero  output  1  divide/remainder by zero occurred.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 SHALL accept a request on a rising edge with in_valid&in_ready&!flush, latching op, A and B; IDLE->BUSY, counter loaded with WIDTH.
REQ-016 SHALL compute multiplies by radix-2 shift-add on magnitudes and divides by radix-2 restoring division on magnitudes, one bit per BUSY cycle, applying operand signs per op (MULH: both signed; MULHSU: A signed, B unsigned; DIV/REM: both signed; U-ops unsigned).
REQ-017 SHALL stay in BUSY exactly WIDTH cycles; out_valid first high WIDTH+1 cycles after the accept edge.
REQ-018 SHALL return the low WIDTH bits for MUL and the high WIDTH bits of the 2*WIDTH product for MULH/MULHSU/MULHU.
REQ-019 SHALL round quotient toward zero; remainder takes the dividend's sign.
REQ-020 SHALL, for divisor zero, bypass BUSY (IDLE->DONE, out_valid 1 cycle after accept), return all-ones for DIV/DIVU and dividend for REM/REMU, and set out_div_zero=1.
REQ-021 SHALL, for signed overflow (A = -2^(WIDTH-1), B = -1, DIV/REM), bypass BUSY likewise, return -2^(WIDTH-1) for DIV and 0 for REM, out_div_zero=0.
REQ-022 SHALL hold out_result and out_div_zero stable in DONE until out_valid&out_ready, then DONE->IDLE; no new accept in that same cycle.
REQ-023 SHALL, when flush=1, go to IDLE on the next edge from any state, discarding the result; flush has priority over accept and over out_ready.
REQ-024 SHALL ignore in_op/in_a/in_b changes while not in IDLE.

Reset
REQ-025 SHALL, on rst_n low at any time, immediately force state IDLE, counter 0, out_valid 0, out_result 0, out_div_zero 0, in_ready 1 once rst_n is high.
REQ-026 SHALL discard any in-flight operation on reset; first accept is possible on the first edge after rst_n deasserts.

Structure
REQ-027 SHALL take op encodings (3-bit codes) and the state enum from a shared package used by the decoder and this unit.
REQ-028 SHALL use one sub-module, md_operand_prep, producing operand magnitudes and result-negate flags from op, A and B.
REQ-029 SHALL share a single 2*WIDTH accumulator/shift register between multiply and divide.

Verification
REQ-030 SHALL verify MUL A=7, B=0xFFFFFFFD (WIDTH=32) -> out_result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-031 SHALL verify A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF.
REQ-032 SHALL verify A=0xFFFFFFF9 (-7), B=2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, DIVU -> 0x7FFFFFFC.
REQ-033 SHALL verify B=0, A=5: DIVU -> 0xFFFFFFFF, REMU -> 5, out_div_zero=1, out_valid 1 cycle after accept; A=0x80000000, B=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
REQ-034 SHALL verify out_ready low 10 cycles in DONE -> result stable, in_ready 0; then out_ready=1 -> IDLE next edge, in_ready 1.
REQ-035 SHALL verify flush in 5th BUSY cycle -> IDLE next edge, no out_valid; rst_n pulsed low mid-BUSY -> out_valid 0 immediately, next request computes correctly.
